// File: rtl/delta_pkg.sv
// Shared widths and FSM state encoding for the delta reconstruction path.
package delta_pkg;

   localparam int W     = 4;
   localparam int CNT_W = 8;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

endpackage

// File: rtl/reconstrutor_delta_if.sv
// Input difference stream and reconstructed-sample output, each with valid/ready.
interface reconstrutor_delta_if #(
   parameter int W = delta_pkg::W
);

   logic         in_valid;
   logic         in_ready;
   logic         in_load;
   logic [W-1:0] in_mag;
   logic         in_neg;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;
   logic         out_ovf;

   modport master (
      output in_valid, in_load, in_mag, in_neg, out_ready,
      input  in_ready, out_valid, out_data, out_ovf
   );

   modport slave (
      input  in_valid, in_load, in_mag, in_neg, out_ready,
      output in_ready, out_valid, out_data, out_ovf
   );

endinterface

// File: rtl/reconstrutor_delta_somador_sinal.sv
// Combinational W-bit signed-direction adder: acc + mag or acc - mag, with carry/borrow.
module somador_sinal #(
   parameter int W = delta_pkg::W
) (
   input  logic [W-1:0] acc,
   input  logic [W-1:0] mag,
   input  logic         neg,
   output logic [W-1:0] sum,
   output logic         ovf
);

   logic [W:0] full;

   // Subtraction as acc + ~mag + 1; mag=0 with neg=1 then carries out and reads as +0.
   assign full = {1'b0, acc} + {1'b0, mag ^ {W{neg}}} + {{W{1'b0}}, neg};
   assign sum  = full[W-1:0];
   // Carry means overflow on add; missing carry means borrow on subtract.
   assign ovf  = full[W] ^ neg;

endmodule

// File: rtl/reconstrutor_delta.sv
// Delta decoder: rebuilds samples from (magnitude, sign) differences after a seed beat.
module reconstrutor_delta #(
   parameter int W     = delta_pkg::W,
   parameter int CNT_W = delta_pkg::CNT_W
) (
   input  logic                 clk,
   input  logic                 rst,
   reconstrutor_delta_if.slave  bus,
   output logic                 err,
   output logic [CNT_W-1:0]     count
);

   import delta_pkg::*;

   state_t       state_q, state_d;
   logic [W-1:0] acc_q;
   logic [W-1:0] sum;
   logic         sum_ovf;
   logic         out_valid_q;
   logic [W-1:0] out_data_q;
   logic         out_ovf_q;
   logic         accept, emit;
   logic         take_sample, err_set, err_clr;
   logic [W-1:0] sample_d;
   logic         ovf_d;

   somador_sinal #(.W(W)) u_somador (
      .acc (acc_q),
      .mag (bus.in_mag),
      .neg (bus.in_neg),
      .sum (sum),
      .ovf (sum_ovf)
   );

   // NOTE: in_ready depends only on out_ready and registered state, never on in_valid,
   // so a producer can gate in_valid on in_ready without forming a combinational loop.
   assign bus.in_ready  = !out_valid_q || bus.out_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_ovf   = out_ovf_q;

   assign accept = bus.in_valid && bus.in_ready;
   assign emit   = out_valid_q && bus.out_ready;

   // NOTE: every signal gets a default before the branches, otherwise a latch is inferred.
   always_comb begin
      state_d     = state_q;
      take_sample = 1'b0;
      sample_d    = sum;
      ovf_d       = sum_ovf;
      err_set     = 1'b0;
      err_clr     = 1'b0;
      if (accept) begin
         if (bus.in_load) begin
            take_sample = 1'b1;
            sample_d    = bus.in_mag;
            ovf_d       = 1'b0;
            err_clr     = 1'b1;
            state_d     = ST_RUN;
         end else if (state_q == ST_RUN) begin
            take_sample = 1'b1;
         end else begin
            err_set = 1'b1;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ovf_q   <= 1'b0;
      end else if (take_sample) begin
         acc_q       <= sample_d;
         out_valid_q <= 1'b1;
         out_data_q  <= sample_d;
         out_ovf_q   <= ovf_d;
      end else if (emit) begin
         out_valid_q <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err   <= 1'b0;
         count <= '0;
      end else begin
         if (err_clr)      err <= 1'b0;
         else if (err_set) err <= 1'b1;
         if (emit) count <= count + CNT_W'(1);
      end
   end

endmodule
